bch_encoder: RTL and testbench
==============================

Name: bch_encoder

Overview:
- Systematic serial-LFSR BCH(31,16) t=3 encoder over GF(2^5), primitive polynomial x^5+x^2+1.
- Transmit-side counterpart of the syndrome calculator: it produces codewords whose six syndromes S1..S6 are all zero.
- Accepts a 16-bit message on a valid/ready handshake, computes 15 parity bits in K clock cycles, then presents the 31-bit codeword on a valid/ready handshake.

Parameters:
- N, 31, codeword length.
- K, 16, message length.
- P, 15, parity length (N-K); degree of generator polynomial.
- GEN, 16'h8FAF, generator g(x)=x^15+x^11+x^10+x^9+x^8+x^7+x^5+x^3+x^2+x+1 (m1·m3·m5); bit i = coefficient of x^i.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- msg_valid  in  1  msg_data is valid.
- msg_ready  out  1  encoder can accept a message.
- msg_data  in  K  message; bit i = coefficient of x^i of m(x).
- cw_valid  out  1  cw_data holds a complete codeword.
- cw_ready  in  1  downstream accepts the codeword.
- cw_data  out  N  codeword; bit j = coefficient of x^j, matching syndrome input r[j].
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - msg_ready=1, cw_valid=0, busy=0, cw_data=0.
  - Parity register, message register and bit counter all cleared.
- Codeword format: c(x) = m(x)·x^15 + (m(x)·x^15 mod g(x)).
  - cw_data[30:15] = message.
  - cw_data[14:0] = parity.
- FSM IDLE:
  - msg_ready=1.
  - On msg_valid && msg_ready: latch msg_data, clear parity register, clear counter, go to SHIFT.
- FSM SHIFT:
  - msg_ready=0.
  - One message bit per edge, MSB first: bit = msg[K-1-cnt].
  - fb = bit ^ par[P-1].
  - par <= {par[P-2:0],1'b0} ^ (fb ? GEN[P-1:0] : 0).
  - cnt increments each edge.
  - On the edge with cnt==K-1: load cw_data, set cw_valid=1, go to DONE.
- FSM DONE:
  - cw_valid=1; cw_data stable.
  - On cw_valid && cw_ready: cw_valid=0, go to IDLE.
- Latency: cw_valid rises exactly K=16 rising edges after the accepting edge.
  - Throughput: one codeword per K+2 cycles minimum (accept edge, K shift edges, one edge for cw handshake).
- Ignored inputs:
  - msg_valid is ignored outside IDLE; msg_ready is low there, so no message is lost.
  - cw_ready asserted outside DONE has no effect.
- Output stability: cw_data changes only on the loading edge and on reset. Between handshakes it holds the last codeword.
- Simultaneous events: msg_valid high in the same cycle DONE completes does not start a new encode that cycle. It is accepted in the following IDLE cycle.
- Reset mid-operation:
  - Aborts immediately to IDLE with the reset values above.
  - No partial codeword is ever presented.
- Width rules:
  - All parity arithmetic is GF(2) (XOR only); no carries.
  - Counter is ceil(log2 K) bits and saturates by the state change, never wraps.

Test Plan:
- Reset check: assert rst_n=0 mid-SHIFT -> msg_ready=1, cw_valid=0, busy=0, cw_data=0 asynchronously; next accepted message encodes correctly.
- Basic vectors, cw_ready tied high:
  - msg 16'h0000 -> cw_data 31'h00000000.
  - msg 16'h0001 -> 31'h00008FAF.
  - msg 16'h0002 -> 31'h00011F5E.
  - msg 16'hFFFF -> 31'h7FFFFFFF.
  - For each, cw_valid rises exactly 16 edges after acceptance.
- Backpressure: cw_ready held low 10 cycles after cw_valid -> cw_data and cw_valid stable; msg_ready=0 and msg_valid ignored throughout; single handshake on release, then IDLE.
- Back-to-back: msg_valid held high with alternating messages -> each accepted only in IDLE, codewords emitted in order, no drops or duplicates.
- Round trip: 1000 random messages fed to the encoder, each codeword into the syndrome calculator -> syndrome1..syndrome6 all 5'b00000 and cw_data[30:15] equals the message.

Source files
------------

// File: rtl/bch_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : bch_encoder_if
// Description : Handshake bundle for the BCH(31,16) encoder. The message side
//               (msg_valid/msg_ready/msg_data) and the codeword side
//               (cw_valid/cw_ready/cw_data) plus the busy status flag.
//               master : the block that feeds messages and takes codewords
//               slave  : the encoder itself
// Revision    : 1.0 - initial release
// ============================================================================
interface bch_encoder_if #(
    parameter int K = 16,
    parameter int N = 31
);
    logic         msg_valid;
    logic         msg_ready;
    logic [K-1:0] msg_data;
    logic         cw_valid;
    logic         cw_ready;
    logic [N-1:0] cw_data;
    logic         busy;

    modport master (
        output msg_valid, msg_data, cw_ready,
        input  msg_ready, cw_valid, cw_data, busy
    );

    modport slave (
        input  msg_valid, msg_data, cw_ready,
        output msg_ready, cw_valid, cw_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/bch_encoder.sv
`default_nettype none
// ============================================================================
// Module      : bch_encoder
// Description : Systematic serial-LFSR BCH(31,16) t=3 encoder, GF(2^5) with
//               primitive polynomial x^5+x^2+1. Codeword is
//               c(x) = m(x)*x^15 + (m(x)*x^15 mod g(x)).
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - slave side of bch_encoder_if:
//                       msg_valid/msg_ready/msg_data[K-1:0] (message in)
//                       cw_valid/cw_ready/cw_data[N-1:0]    (codeword out)
//                       busy (high while shifting or holding a codeword)
// Revision    : 1.0 - initial release
// ============================================================================
module bch_encoder #(
    parameter int          N   = 31,
    parameter int          K   = 16,
    parameter int          P   = 15,
    parameter logic [15:0] GEN = 16'h8FAF
) (
    input  wire              clk,
    input  wire              rst_n,
    bch_encoder_if.slave     bus
);

    localparam int             CW     = $clog2(K);
    localparam logic [CW-1:0]  C_LAST = CW'(K - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [K-1:0]    msg_q,   msg_d;
    logic [P-1:0]    par_q,   par_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [N-1:0]    cw_q,    cw_d;

    logic            w_bit;
    logic            w_fb;
    logic [P-1:0]    w_par_next;

    // Message is consumed MSB first; the register itself is kept intact so
    // it can be placed verbatim in the upper codeword bits.
    assign w_bit      = msg_q[C_LAST - cnt_q];
    assign w_fb       = w_bit ^ par_q[P-1];
    assign w_par_next = {par_q[P-2:0], 1'b0} ^ (w_fb ? GEN[P-1:0] : {P{1'b0}});

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        cw_d    = cw_q;
        unique case (state_q)
            IDLE: begin
                if (bus.msg_valid) begin
                    msg_d   = bus.msg_data;
                    par_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                par_d = w_par_next;
                if (cnt_q == C_LAST) begin
                    // Final division step: the remainder is complete now,
                    // so the codeword is built from the next-state parity.
                    cw_d    = {msg_q, w_par_next};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.cw_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            msg_q   <= '0;
            par_q   <= '0;
            cnt_q   <= '0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            cw_q    <= cw_d;
        end
    end

    assign bus.msg_ready = (state_q == IDLE);
    assign bus.cw_valid  = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.cw_data   = cw_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bch_encoder
// Description : Self-checking bench for bch_encoder. Accepted messages go
//               into a scoreboard queue; each codeword handshake pops one and
//               compares against a long-division reference and a GF(2^5)
//               syndrome evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bch_encoder;

    localparam int          N   = 31;
    localparam int          K   = 16;
    localparam logic [15:0] GEN = 16'h8FAF;

    logic clk;
    logic rst_n;

    bch_encoder_if #(.K(K), .N(N)) bus ();

    bch_encoder #(.N(N), .K(K), .P(15), .GEN(GEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [K-1:0] sb[$];
    logic [N-1:0] last_cw = '0;
    int           cyc     = 0;
    int           acc_cyc = 0;
    int           n_pop   = 0;
    logic         prev_cwv = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: plain polynomial long division of m(x)*x^15 by g(x).
    function automatic logic [N-1:0] enc(input logic [K-1:0] m);
        logic [N-1:0] r;
        logic [N-1:0] g;
        r = {m, 15'b0};
        g = N'(GEN);
        for (int i = N - 1; i >= 15; i--)
            if (r[i]) r = r ^ (g << (i - 15));
        return {m, r[14:0]};
    endfunction

    function automatic logic [4:0] apow(input int e);
        logic [4:0] v;
        v = 5'd1;
        for (int i = 0; i < (e % 31); i++)
            v = v[4] ? ((v << 1) ^ 5'b00101) : (v << 1);
        return v;
    endfunction

    // S1..S6 packed, S1 in the low bits.
    function automatic logic [29:0] syndromes(input logic [N-1:0] c);
        logic [29:0] r;
        logic [4:0]  s;
        r = '0;
        for (int j = 1; j <= 6; j++) begin
            s = '0;
            for (int k = 0; k < N; k++)
                if (c[k]) s = s ^ apow(j * k);
            r[5*(j-1) +: 5] = s;
        end
        return r;
    endfunction

    // Monitor: observe handshakes on the falling edge, where the values the
    // next rising edge will act on are stable.
    always @(negedge clk) begin
        logic [K-1:0] m;
        cyc++;
        if (!rst_n) begin
            prev_cwv = 1'b0;
        end else begin
            if (bus.cw_valid && !prev_cwv)
                chk("latency", 64'(cyc - acc_cyc), 64'd17);
            if (bus.cw_valid) begin
                chk("msg_ready_in_done", 64'(bus.msg_ready), 64'd0);
                chk("busy_in_done", 64'(bus.busy), 64'd1);
            end
            if (bus.msg_valid && bus.msg_ready) begin
                sb.push_back(bus.msg_data);
                acc_cyc = cyc;
            end
            if (bus.cw_valid && bus.cw_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_cw observed=%0h expected=none", bus.cw_data);
                end else begin
                    m = sb.pop_front();
                    chk("cw_data", 64'(bus.cw_data), 64'(enc(m)));
                    chk("cw_msg_field", 64'(bus.cw_data[30:15]), 64'(m));
                    chk("syndromes", 64'(syndromes(bus.cw_data)), 64'd0);
                    last_cw = bus.cw_data;
                    n_pop++;
                end
            end
            prev_cwv = bus.cw_valid;
        end
    end

    task automatic wait_accept();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.msg_ready) break;
        end
        chk("accept_timeout", 64'(bus.msg_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.msg_valid = 1'b0;
    endtask

    task automatic send(input logic [K-1:0] m);
        @(posedge clk);
        #1;
        bus.msg_valid = 1'b1;
        bus.msg_data  = m;
        wait_accept();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.msg_ready) break;
        end
        chk("idle_timeout", 64'(bus.msg_ready), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [K-1:0] vec_m  [4];
        logic [N-1:0] vec_cw [4];
        logic [K-1:0] m;
        int           pops0;

        vec_m[0] = 16'h0000; vec_cw[0] = 31'h00000000;
        vec_m[1] = 16'h0001; vec_cw[1] = 31'h00008FAF;
        vec_m[2] = 16'h0002; vec_cw[2] = 31'h00011F5E;
        vec_m[3] = 16'hFFFF; vec_cw[3] = 31'h7FFFFFFF;

        rst_n         = 1'b0;
        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
        bus.cw_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_msg_ready", 64'(bus.msg_ready), 64'd1);
        chk("rst_cw_valid",  64'(bus.cw_valid),  64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_cw_data",   64'(bus.cw_data),   64'd0);
        rst_n = 1'b1;

        // Basic vectors
        for (int i = 0; i < 4; i++) begin
            send(vec_m[i]);
            chk("busy_in_shift", 64'(bus.busy), 64'd1);
            wait_idle();
            chk("vector", 64'(last_cw), 64'(vec_cw[i]));
        end

        // Asynchronous reset in the middle of SHIFT
        send(16'hA5C3);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_msg_ready", 64'(bus.msg_ready), 64'd1);
        chk("async_cw_valid",  64'(bus.cw_valid),  64'd0);
        chk("async_busy",      64'(bus.busy),      64'd0);
        chk("async_cw_data",   64'(bus.cw_data),   64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'h0002);
        wait_idle();
        chk("post_reset_vector", 64'(last_cw), 64'h00011F5E);

        // Backpressure: hold cw_ready low 10 cycles with msg_valid pushing
        bus.cw_ready = 1'b0;
        send(16'h1234);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.cw_valid) break;
        end
        chk("bp_cw_valid_rise", 64'(bus.cw_valid), 64'd1);
        @(posedge clk);
        #1;
        bus.msg_valid = 1'b1;
        bus.msg_data  = 16'hBEEF;
        pops0 = n_pop;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_cw_valid", 64'(bus.cw_valid),  64'd1);
            chk("bp_cw_data",  64'(bus.cw_data),   64'(enc(16'h1234)));
            chk("bp_msg_ready", 64'(bus.msg_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.cw_ready = 1'b1;
        wait_accept();
        chk("bp_single_handshake", 64'(n_pop - pops0), 64'd1);
        wait_idle();
        chk("bp_followup", 64'(last_cw), 64'(enc(16'hBEEF)));

        // Back-to-back with msg_valid held high, alternating data
        pops0 = n_pop;
        @(posedge clk);
        #1;
        bus.msg_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.msg_data = (i % 2 == 0) ? 16'h5555 : 16'hAAAA;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (bus.msg_ready) break;
            end
            @(posedge clk);
            #1;
        end
        bus.msg_valid = 1'b0;
        wait_idle();
        chk("b2b_count", 64'(n_pop - pops0), 64'd6);
        chk("b2b_last", 64'(last_cw), 64'(enc(16'hAAAA)));

        // Round trip with random messages
        for (int i = 0; i < 1000; i++) begin
            m = 16'($urandom);
            send(m);
            wait_idle();
        end
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
